// File: rtl/tdl_pkg.sv
// Shared types and helpers for the multi-channel tapped delay line.
package tdl_pkg;

  localparam int SAMPLE_W = 13;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } flush_state_e;

  // Zero or out-of-range programmed depths fall back to the full line.
  function automatic int depth_eff(input int depth, input int taps);
    return ((depth == 0) || (depth > taps)) ? taps : depth;
  endfunction

endpackage

// File: rtl/tdl_mc_if.sv
// Sample/snapshot bus between the FIR front end and the tapped delay line.
interface tdl_mc_if #(
  parameter int DATA_WIDTH = 13,
  parameter int TAPS       = 8,
  parameter int CHANNELS   = 4
);
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int DEP_W = $clog2(TAPS + 1);

  logic                               VIN;
  logic                               READY;
  logic [CH_W-1:0]                    CH_IN;
  logic signed [DATA_WIDTH-1:0]       DIN;
  logic [DEP_W-1:0]                   DEPTH;
  logic                               FLUSH;
  logic                               VOUT;
  logic [CH_W-1:0]                    CH_OUT;
  logic [TAPS-1:0][DATA_WIDTH-1:0]    TP;
  logic                               FULL;
  logic                               BUSY;
  logic                               ERR;

  modport master (
    output VIN, CH_IN, DIN, DEPTH, FLUSH,
    input  READY, VOUT, CH_OUT, TP, FULL, BUSY, ERR
  );

  modport slave (
    input  VIN, CH_IN, DIN, DEPTH, FLUSH,
    output READY, VOUT, CH_OUT, TP, FULL, BUSY, ERR
  );
endinterface

// File: rtl/tdl_line.sv
// One channel's sample history: shift register plus saturating fill counter.
module tdl_line #(
  parameter int DATA_WIDTH = 13,
  parameter int TAPS       = 8,
  parameter int FILL_W     = 4
) (
  input  logic                            CLK,
  input  logic                            RST_n,
  input  logic                            shift_en_i,
  input  logic                            clear_i,
  input  logic [DATA_WIDTH-1:0]           din_i,
  output logic [TAPS-1:0][DATA_WIDTH-1:0] line_o,
  output logic [FILL_W-1:0]               fill_o
);
  localparam logic [FILL_W-1:0] TAPS_F = FILL_W'(TAPS);

  logic [TAPS-1:0][DATA_WIDTH-1:0] line_q;
  logic [FILL_W-1:0]               fill_q;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      line_q <= '0;
      fill_q <= '0;
    end else if (clear_i) begin
      line_q <= '0;
      fill_q <= '0;
    end else if (shift_en_i) begin
      line_q <= {line_q[TAPS-2:0], din_i};
      if (fill_q != TAPS_F) fill_q <= fill_q + 1'b1;
    end
  end

  assign line_o = line_q;
  assign fill_o = fill_q;
endmodule

// File: rtl/tdl_mc.sv
// Multi-channel tapped delay line: flush sequencer, channel decode, snapshot register.
//   state | meaning
//   IDLE  | accepting samples, READY=1
//   CLEAR | wiping channel cc_q per cycle, READY=0, BUSY=1
module tdl_mc
  import tdl_pkg::*;
#(
  parameter int DATA_WIDTH = SAMPLE_W,
  parameter int TAPS       = 8,
  parameter int CHANNELS   = 4
) (
  input logic       CLK,
  input logic       RST_n,
  tdl_mc_if.slave   bus
);
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int DEP_W = $clog2(TAPS + 1);
  localparam logic [CH_W:0]    NUM_CH  = (CH_W+1)'(CHANNELS);
  localparam logic [CH_W-1:0]  LAST_CH = CH_W'(CHANNELS - 1);
  localparam logic [DEP_W-1:0] TAPS_F  = DEP_W'(TAPS);

  typedef logic [TAPS-1:0][DATA_WIDTH-1:0] taps_t;

  flush_state_e     state_q, state_d;
  logic [CH_W-1:0]  cc_q, cc_d;
  logic             ch_valid, accept, bad;

  taps_t            line_w [CHANNELS];
  logic [DEP_W-1:0] fill_w [CHANNELS];
  logic [CHANNELS-1:0] shift_en, clr;

  taps_t            sel_line, post_line, tp_d, tp_q;
  logic [DEP_W-1:0] sel_fill, fill_post;
  int               deff;
  logic             full_d, full_q, vout_q, err_q;
  logic [CH_W-1:0]  ch_out_q;

  assign ch_valid = ({1'b0, bus.CH_IN} < NUM_CH);

  always_comb begin
    state_d = state_q;
    cc_d    = cc_q;
    accept  = 1'b0;
    bad     = 1'b0;
    case (state_q)
      IDLE: begin
        accept = bus.VIN && ch_valid;
        bad    = bus.VIN && !ch_valid;
        if (bus.FLUSH) begin
          state_d = CLEAR;
          cc_d    = '0;
        end
      end
      CLEAR: begin
        if (cc_q == LAST_CH) state_d = IDLE;
        else                 cc_d    = cc_q + 1'b1;
      end
    endcase
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_line
    assign shift_en[c] = accept && (bus.CH_IN == CH_W'(c));
    assign clr[c]      = (state_q == CLEAR) && (cc_q == CH_W'(c));

    tdl_line #(
      .DATA_WIDTH (DATA_WIDTH),
      .TAPS       (TAPS),
      .FILL_W     (DEP_W)
    ) u_line (
      .CLK        (CLK),
      .RST_n      (RST_n),
      .shift_en_i (shift_en[c]),
      .clear_i    (clr[c]),
      .din_i      (bus.DIN),
      .line_o     (line_w[c]),
      .fill_o     (fill_w[c])
    );
  end

  // Snapshot is built from the post-shift view so it matches what the line holds next cycle.
  always_comb begin
    sel_line = '0;
    sel_fill = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (bus.CH_IN == CH_W'(c)) begin
        sel_line = line_w[c];
        sel_fill = fill_w[c];
      end
    end
    post_line[0] = bus.DIN;
    for (int k = 1; k < TAPS; k++) post_line[k] = sel_line[k-1];
    fill_post = (sel_fill == TAPS_F) ? sel_fill : sel_fill + 1'b1;
    deff      = depth_eff(int'(bus.DEPTH), TAPS);
    for (int k = 0; k < TAPS; k++) tp_d[k] = (k < deff) ? post_line[k] : '0;
    full_d = (int'(fill_post) >= deff);
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q  <= IDLE;
      cc_q     <= '0;
      vout_q   <= 1'b0;
      err_q    <= 1'b0;
      full_q   <= 1'b0;
      ch_out_q <= '0;
      tp_q     <= '0;
    end else begin
      state_q <= state_d;
      cc_q    <= cc_d;
      vout_q  <= accept;
      err_q   <= bad;
      if (accept) begin
        tp_q     <= tp_d;
        ch_out_q <= bus.CH_IN;
        full_q   <= full_d;
      end
    end
  end

  assign bus.READY  = (state_q == IDLE);
  assign bus.BUSY   = (state_q == CLEAR);
  assign bus.VOUT   = vout_q;
  assign bus.ERR    = err_q;
  assign bus.TP     = tp_q;
  assign bus.CH_OUT = ch_out_q;
  assign bus.FULL   = full_q;
endmodule

// File: tb/tb_tdl_mc.sv
// Scoreboarded bench for tdl_mc: 4-channel instance with a reference model, 3-channel instance for bad-channel handling.
module tb_tdl_mc;
  localparam int DW   = 13;
  localparam int TAPS = 8;
  localparam int NCH  = 4;

  typedef logic [TAPS-1:0][DW-1:0] taps_t;
  typedef struct {
    int    ch;
    taps_t tp;
    logic  full;
  } snap_t;

  logic CLK = 1'b0;
  logic RST_n = 1'b0;
  always #5 CLK = ~CLK;

  tdl_mc_if #(.DATA_WIDTH(DW), .TAPS(TAPS), .CHANNELS(NCH)) bus4 ();
  tdl_mc_if #(.DATA_WIDTH(DW), .TAPS(TAPS), .CHANNELS(3))   bus3 ();

  tdl_mc #(.DATA_WIDTH(DW), .TAPS(TAPS), .CHANNELS(NCH)) u_dut4 (
    .CLK   (CLK),
    .RST_n (RST_n),
    .bus   (bus4.slave)
  );

  tdl_mc #(.DATA_WIDTH(DW), .TAPS(TAPS), .CHANNELS(3)) u_dut3 (
    .CLK   (CLK),
    .RST_n (RST_n),
    .bus   (bus3.slave)
  );

  int    checks = 0;
  int    failures = 0;
  int    m_line [NCH][TAPS];
  int    m_fill [NCH];
  snap_t sbq [$];
  snap_t mon_s;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_fill[c] = 0;
      for (int k = 0; k < TAPS; k++) m_line[c][k] = 0;
    end
  endtask

  // Drives one sample for a cycle and pushes the model's expected snapshot.
  task automatic send(input int ch, input int din, input int depth, input bit flush = 1'b0);
    snap_t s;
    int    deff;
    bus4.VIN   = 1'b1;
    bus4.CH_IN = 2'(ch);
    bus4.DIN   = 13'(din);
    bus4.DEPTH = 4'(depth);
    bus4.FLUSH = flush;
    deff = (depth == 0 || depth > TAPS) ? TAPS : depth;
    for (int k = TAPS - 1; k > 0; k--) m_line[ch][k] = m_line[ch][k-1];
    m_line[ch][0] = din;
    if (m_fill[ch] < TAPS) m_fill[ch]++;
    s.ch = ch;
    for (int k = 0; k < TAPS; k++) s.tp[k] = (k < deff) ? 13'(m_line[ch][k]) : 13'd0;
    s.full = (m_fill[ch] >= deff);
    sbq.push_back(s);
    if (flush) model_reset();
    @(negedge CLK);
    bus4.VIN   = 1'b0;
    bus4.FLUSH = 1'b0;
  endtask

  always @(negedge CLK) begin
    if (RST_n && bus4.VOUT === 1'b1) begin
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_vout got ch=%0d tp=%h, nothing expected", bus4.CH_OUT, bus4.TP);
      end else begin
        mon_s = sbq.pop_front();
        if (bus4.CH_OUT !== 2'(mon_s.ch)) begin
          failures++;
          $display("FAIL sb_ch_out got=%0d exp=%0d", bus4.CH_OUT, mon_s.ch);
        end
        checks++;
        if (bus4.TP !== mon_s.tp) begin
          failures++;
          $display("FAIL sb_tp ch=%0d got=%h exp=%h", mon_s.ch, bus4.TP, mon_s.tp);
        end
        checks++;
        if (bus4.FULL !== mon_s.full) begin
          failures++;
          $display("FAIL sb_full ch=%0d got=%b exp=%b", mon_s.ch, bus4.FULL, mon_s.full);
        end
      end
    end
  end

  task automatic drain(input string name);
    @(negedge CLK);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL %s_missing_vout got=%0d pending exp=0", name, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_reset();
    bus4.VIN = 0; bus4.CH_IN = 0; bus4.DIN = 0; bus4.DEPTH = 0; bus4.FLUSH = 0;
    bus3.VIN = 0; bus3.CH_IN = 0; bus3.DIN = 0; bus3.DEPTH = 0; bus3.FLUSH = 0;
    model_reset();
    RST_n = 1'b0;
    #3;
    checks++;
    if ({bus4.READY, bus4.BUSY, bus4.VOUT, bus4.FULL, bus4.ERR} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=10000", {bus4.READY, bus4.BUSY, bus4.VOUT, bus4.FULL, bus4.ERR});
    end
    checks++;
    if (bus4.TP !== '0 || bus4.CH_OUT !== 2'd0) begin
      failures++;
      $display("FAIL reset_data got tp=%h ch=%0d exp=0", bus4.TP, bus4.CH_OUT);
    end
    @(negedge CLK);
    RST_n = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_single_channel();
    taps_t exp;
    for (int i = 1; i <= 9; i++) begin
      send(0, i, 8);
      checks++;
      if (bus4.FULL !== (i >= 8)) begin
        failures++;
        $display("FAIL single_full sample=%0d got=%b exp=%b", i, bus4.FULL, (i >= 8));
      end
    end
    for (int k = 0; k < TAPS; k++) exp[k] = 13'(9 - k);
    checks++;
    if (bus4.TP !== exp) begin
      failures++;
      $display("FAIL single_tp got=%h exp=%h", bus4.TP, exp);
    end
    drain("single");
  endtask

  task automatic test_interleave();
    taps_t exp;
    for (int i = 0; i < 4; i++) begin
      send(0, 100, 8);
      if (i == 3) begin
        checks++;
        if (bus4.TP[3:0] !== {4{13'd100}}) begin
          failures++;
          $display("FAIL ilv_ch0_tp got=%h exp=4x100", bus4.TP);
        end
      end
      send(1, -5, 8);
    end
    for (int k = 0; k < TAPS; k++) exp[k] = (k < 4) ? 13'h1ffb : 13'd0;
    checks++;
    if (bus4.TP !== exp || bus4.FULL !== 1'b0) begin
      failures++;
      $display("FAIL ilv_ch1 got tp=%h full=%b exp tp=%h full=0", bus4.TP, bus4.FULL, exp);
    end
    drain("ilv");
  endtask

  task automatic test_depth();
    taps_t exp;
    for (int i = 1; i <= 4; i++) begin
      send(2, 10 * i, 3);
      checks++;
      if (bus4.FULL !== (i >= 3)) begin
        failures++;
        $display("FAIL depth3_full sample=%0d got=%b exp=%b", i, bus4.FULL, (i >= 3));
      end
    end
    exp = '0;
    exp[0] = 13'd40; exp[1] = 13'd30; exp[2] = 13'd20;
    checks++;
    if (bus4.TP !== exp) begin
      failures++;
      $display("FAIL depth3_tp got=%h exp=%h", bus4.TP, exp);
    end
    send(3, 5, 0);
    send(3, 6, 0);
    send(3, 7, 12);
    exp = '0;
    exp[0] = 13'd7; exp[1] = 13'd6; exp[2] = 13'd5;
    checks++;
    if (bus4.TP !== exp) begin
      failures++;
      $display("FAIL depth_clamp_tp got=%h exp=%h", bus4.TP, exp);
    end
    drain("depth");
  endtask

  task automatic test_bad_channel();
    taps_t exp;
    bus3.DEPTH = 4'd8;
    bus3.VIN = 1; bus3.CH_IN = 2'd0; bus3.DIN = 13'd11;
    @(negedge CLK);
    bus3.CH_IN = 2'd3; bus3.DIN = 13'd99;
    @(negedge CLK);
    checks++;
    if (bus3.ERR !== 1'b1 || bus3.VOUT !== 1'b0) begin
      failures++;
      $display("FAIL err_pulse got err=%b vout=%b exp err=1 vout=0", bus3.ERR, bus3.VOUT);
    end
    bus3.VIN = 0;
    @(negedge CLK);
    checks++;
    if (bus3.ERR !== 1'b0 || bus3.VOUT !== 1'b0) begin
      failures++;
      $display("FAIL err_width got err=%b vout=%b exp err=0 vout=0", bus3.ERR, bus3.VOUT);
    end
    bus3.VIN = 1; bus3.CH_IN = 2'd0; bus3.DIN = 13'd12;
    @(negedge CLK);
    bus3.VIN = 0;
    exp = '0;
    exp[0] = 13'd12; exp[1] = 13'd11;
    checks++;
    if (bus3.VOUT !== 1'b1 || bus3.TP !== exp || bus3.CH_OUT !== 2'd0) begin
      failures++;
      $display("FAIL err_no_data got vout=%b tp=%h ch=%0d exp vout=1 tp=%h ch=0", bus3.VOUT, bus3.TP, bus3.CH_OUT, exp);
    end
  endtask

  task automatic test_flush();
    taps_t exp;
    for (int i = 1; i <= 8; i++) send(0, i, 8);
    send(0, 50, 8, 1'b1);
    for (int i = 0; i <= 4; i++) begin
      checks++;
      if (bus4.READY !== (i == 4) || bus4.BUSY !== (i != 4)) begin
        failures++;
        $display("FAIL flush_ready cycle=%0d got ready=%b busy=%b exp ready=%b", i, bus4.READY, bus4.BUSY, (i == 4));
      end
      if (i < 4) begin
        bus4.VIN = 1; bus4.CH_IN = 2'd1; bus4.DIN = 13'd77; bus4.FLUSH = (i == 1);
        @(negedge CLK);
      end
    end
    bus4.VIN = 0;
    bus4.FLUSH = 0;
    send(0, 7, 8);
    exp = '0;
    exp[0] = 13'd7;
    checks++;
    if (bus4.TP !== exp || bus4.FULL !== 1'b0) begin
      failures++;
      $display("FAIL flush_after got tp=%h full=%b exp tp=%h full=0", bus4.TP, bus4.FULL, exp);
    end
    drain("flush");
  endtask

  task automatic test_reset_midstream(input bit during_clear);
    taps_t exp;
    if (during_clear) begin
      send(2, 9, 8, 1'b1);
      @(negedge CLK);
    end else begin
      send(1, 21, 8);
      send(1, 22, 8);
    end
    #2;
    RST_n = 1'b0;
    #1;
    checks++;
    if ({bus4.READY, bus4.BUSY, bus4.VOUT, bus4.FULL, bus4.ERR} !== 5'b10000 ||
        bus4.TP !== '0 || bus4.CH_OUT !== 2'd0) begin
      failures++;
      $display("FAIL rst_mid clear=%0d got flags=%b tp=%h ch=%0d exp flags=10000 tp=0 ch=0",
               during_clear, {bus4.READY, bus4.BUSY, bus4.VOUT, bus4.FULL, bus4.ERR}, bus4.TP, bus4.CH_OUT);
    end
    sbq.delete();
    model_reset();
    @(negedge CLK);
    #2;
    RST_n = 1'b1;
    @(negedge CLK);
    checks++;
    if (bus4.READY !== 1'b1) begin
      failures++;
      $display("FAIL rst_ready got=%b exp=1", bus4.READY);
    end
    send(3, 44, 8);
    exp = '0;
    exp[0] = 13'd44;
    checks++;
    if (bus4.TP !== exp) begin
      failures++;
      $display("FAIL rst_first got=%h exp=%h", bus4.TP, exp);
    end
    drain("rst");
  endtask

  initial begin
    fork
      begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
      end
    join_none
    test_reset();
    test_single_channel();
    test_interleave();
    test_depth();
    test_bad_channel();
    test_flush();
    test_reset_midstream(1'b0);
    test_reset_midstream(1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tdl_mc.md
Name: tdl_mc

Overview:
- Multi-channel, depth-programmable tapped delay line for the FIR datapath.
- Keeps one independent TAPS-deep sample history per channel for time-interleaved streams.
- Each accepted sample yields a registered tap snapshot of that channel for the MAC array, plus a warm-up flag, a flush sequencer and a ready handshake.

Parameters:
- DATA_WIDTH, 13, signed sample width.
- TAPS, 8, maximum taps per channel (≥2).
- CHANNELS, 4, number of independent delay lines (≥1).
- CH_W, $clog2(CHANNELS) min 1, channel index width.
- DEP_W, $clog2(TAPS+1), DEPTH field width.

Ports:
- CLK  in  1  clock; single clock domain.
- RST_n  in  1  reset, asynchronous assert, active low.
- VIN  in  1  input sample valid.
- READY  out  1  block can accept; VIN is accepted only when VIN && READY.
- CH_IN  in  CH_W  channel of DIN.
- DIN  in  DATA_WIDTH signed  input sample.
- DEPTH  in  DEP_W  active tap count; 0 or >TAPS is treated as TAPS.
- FLUSH  in  1  request to clear all channels.
- VOUT  out  1  snapshot valid, one-cycle pulse.
- CH_OUT  out  CH_W  channel of snapshot.
- TP  out  TAPS x DATA_WIDTH signed  tap snapshot; TP[0] is newest.
- FULL  out  1  snapshot channel holds ≥ DEPTH_eff samples.
- BUSY  out  1  flush in progress.
- ERR  out  1  one-cycle pulse: VIN with CH_IN ≥ CHANNELS.

Behaviour:
- Reset (async, RST_n=0):
  - All line storage, fill counters, TP, CH_OUT, VOUT, FULL, ERR, BUSY = 0.
  - FSM = IDLE, READY = 1.
- Storage:
  - line[c][k], c<CHANNELS, k<TAPS.
  - fill[c] is a saturating counter, 0..TAPS.
- Accept (IDLE, VIN=1, CH_IN<CHANNELS):
  - line[CH_IN][0] <= DIN; line[CH_IN][k] <= line[CH_IN][k-1] for k≥1; oldest sample discarded.
  - fill[CH_IN] <= min(fill+1, TAPS).
  - Other channels untouched.
- Snapshot, registered, latency 1 cycle after accept:
  - VOUT=1, CH_OUT=CH_IN.
  - TP[k] = post-shift line[CH_IN][k] for k < DEPTH_eff, else 0.
  - FULL = (post-increment fill ≥ DEPTH_eff).
  - DEPTH is sampled in the accept cycle.
  - TP, CH_OUT and FULL hold their values when VOUT=0.
- Bad channel (VIN=1, CH_IN ≥ CHANNELS, IDLE):
  - No storage change, no VOUT; ERR=1 next cycle.
- FSM IDLE:
  - READY=1, BUSY=0.
  - FLUSH=1 → CLEAR next cycle; clear counter cc=0.
  - VIN in the same cycle as FLUSH is still accepted and its VOUT is still issued; the flush then clears it.
- FSM CLEAR:
  - READY=0, BUSY=1.
  - Each cycle: line[cc][*]=0, fill[cc]=0, cc++.
  - After cc=CHANNELS-1 → IDLE, so READY=0 for exactly CHANNELS cycles.
  - VIN is ignored (no ERR, no VOUT). FLUSH is ignored.
  - Outputs TP/CH_OUT/FULL are not cleared by flush.
- Reset during CLEAR aborts the flush; full reset state applies.
- Arithmetic: no arithmetic on samples; data moves bit-exact, signed.

Decomposition:
- Package tdl_pkg:
  - sample_t (signed DATA_WIDTH).
  - FSM enum flush_state_e {IDLE, CLEAR}.
  - Function depth_eff(DEPTH, TAPS) for the clamp.
- Natural sub-module: tdl_line, one channel's shift register plus fill counter with shift_en/clear inputs, instantiated CHANNELS times via generate.
- The top level holds the FSM, channel decode, mux and output register.

Test Plan:
- Ch0 only, DEPTH=8, DIN=1..9 consecutive → VOUT each cycle at +1 latency; after 9th sample TP=[9,8,7,6,5,4,3,2]; FULL first high on the 8th snapshot.
- Alternate ch0=100 and ch1=-5, 4 samples each → final ch1 snapshot TP[0..3]=-5, TP[4..7]=0, FULL=0; ch0 snapshot TP[0..3]=100; no cross-talk.
- DEPTH=3, ch2 DIN=10,20,30,40 → last TP=[40,30,20,0,0,0,0,0]; FULL high from the 3rd snapshot; DEPTH=0 behaves as 8.
- Fill ch0 with 1..8, pulse FLUSH with VIN=1 DIN=50 → VOUT for 50 emitted; READY low exactly 4 cycles; VIN ignored during flush; next ch0 sample 7 → TP=[7,0,...], FULL=0.
- CHANNELS=3, VIN with CH_IN=3 → ERR pulse 1 cycle later, no VOUT, later ch0 snapshot shows no data from it.
- Assert RST_n low mid-stream and mid-CLEAR → all outputs 0 immediately; READY=1 after release; the first sample gives TP=[d,0,...].
